// File: rtl/cam_match_reader.sv
// cam_match_reader: search-side front end for an 8-entry combinational CAM.
// It registers a search key onto the CAM, captures the match lines once, and
// then returns each matching address, lowest index first, one per rsp handshake.
//
// Handshake contract (both sides):
//   * A transfer happens on a rising clk edge where valid & ready are both high.
//   * valid never depends on ready.
//   * The payload is held stable while valid is high and ready is low.
//   * req_ready depends only on state and rst_n, never on rsp_ready.
module cam_match_reader #(
    parameter int ENTRIES = 8,
    parameter int KEY_W   = 8,
    parameter int ADDR_W  = 3,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [KEY_W-1:0]   req_key,
    output logic [KEY_W-1:0]   cam_key,
    input  logic [ENTRIES-1:0] srch,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ADDR_W-1:0]  rsp_addr,
    output logic               rsp_hit,
    output logic               rsp_last,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        EMIT   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   cam_key_q, cam_key_d;
    logic [ENTRIES-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]   match_count_q, match_count_d;

    logic [CNT_W-1:0]   srch_pop;
    logic [ADDR_W-1:0]  low_idx;
    logic [ENTRIES-1:0] low_onehot;
    logic               multi_pending;

    // Number of match lines asserted this cycle; only used when capturing.
    always_comb begin
        srch_pop = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            srch_pop = srch_pop + CNT_W'(srch[i]);
        end
    end

    // Lowest pending index, its one-hot mask, and whether more than one remains.
    // All derived from registered state so srch has no path to the rsp outputs.
    always_comb begin
        low_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = ADDR_W'(i);
            end
        end
        low_onehot    = pending_q & (~pending_q + ENTRIES'(1));
        multi_pending = |(pending_q & (pending_q - ENTRIES'(1)));
    end

    // Next-state and register updates for the IDLE -> SAMPLE -> EMIT sequence.
    always_comb begin
        state_d       = state_q;
        cam_key_d     = cam_key_q;
        pending_d     = pending_q;
        match_count_d = match_count_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cam_key_d = req_key;
                    state_d   = SAMPLE;
                end
            end
            SAMPLE: begin
                // CAM is combinational: srch already reflects cam_key_q here.
                pending_d     = srch;
                match_count_d = srch_pop;
                state_d       = EMIT;
            end
            EMIT: begin
                if (rsp_ready) begin
                    pending_d = pending_q & ~low_onehot;
                    if (!multi_pending) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; synchronous reset aborts any search in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cam_key_q     <= '0;
            pending_q     <= '0;
            match_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cam_key_q     <= cam_key_d;
            pending_q     <= pending_d;
            match_count_q <= match_count_d;
        end
    end

    // Output decode; an empty capture yields one no-hit, last response at addr 0.
    always_comb begin
        req_ready   = rst_n && (state_q == IDLE);
        busy        = (state_q != IDLE);
        rsp_valid   = (state_q == EMIT);
        rsp_addr    = low_idx;
        rsp_hit     = |pending_q;
        rsp_last    = !multi_pending;
        cam_key     = cam_key_q;
        match_count = match_count_q;
    end

endmodule
